// File: rtl/hdmi_timing_gen.sv
// -----------------------------------------------------------------------------
// hdmi_timing_gen
// Video timing generator for a 1280x720@60 raster (defaults). Issues per-pixel
// coordinate requests to the overlay/frame-buffer read path and accepts the
// RGB565 reply one cycle later. It emits sync, data enable and 24-bit RGB,
// all aligned two registers after the request stage, to the TMDS encoder.
//
// Optional build macro: HDMI_TIMING_GEN_TEST_PATTERN_EN
//   When it is defined and pattern_en is latched high at frame_start, the
//   output shows 8 vertical colour bars instead of pixel_data.
//
// Ports:
//   hdmi_clk     in   pixel clock
//   sys_rst_n    in   asynchronous active-low reset
//   pixel_data   in   RGB565 reply, valid 1 cycle after its data_req
//   pattern_en   in   colour-bar select (test-pattern builds only)
//   data_req     out  pixel request for pixel_xpos/pixel_ypos
//   pixel_xpos   out  active column, 0 when data_req is low
//   pixel_ypos   out  active row, 0 when data_req is low
//   video_hs     out  horizontal sync (polarity set by SYNC_POL)
//   video_vs     out  vertical sync (polarity set by SYNC_POL)
//   video_de     out  data enable
//   video_rgb    out  {R8,G8,B8}, zero outside video_de
//   frame_start  out  one-cycle pulse marking h=0,v=0 at the output stage
// -----------------------------------------------------------------------------
module hdmi_timing_gen #(
  parameter int H_SYNC   = 40,
  parameter int H_BACK   = 220,
  parameter int H_DISP   = 1280,
  parameter int H_FRONT  = 110,
  parameter int V_SYNC   = 5,
  parameter int V_BACK   = 20,
  parameter int V_DISP   = 720,
  parameter int V_FRONT  = 5,
  parameter int SYNC_POL = 1
) (
  input  logic        hdmi_clk,
  input  logic        sys_rst_n,
  input  logic [15:0] pixel_data,
  input  logic        pattern_en,
  output logic        data_req,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic        video_hs,
  output logic        video_vs,
  output logic        video_de,
  output logic [23:0] video_rgb,
  output logic        frame_start
);

  localparam logic [11:0] H_TOTAL = 12'(H_SYNC + H_BACK + H_DISP + H_FRONT);
  localparam logic [11:0] V_TOTAL = 12'(V_SYNC + V_BACK + V_DISP + V_FRONT);
  localparam logic [11:0] HA      = 12'(H_SYNC + H_BACK);
  localparam logic [11:0] HA_END  = 12'(H_SYNC + H_BACK + H_DISP);
  localparam logic [11:0] VA      = 12'(V_SYNC + V_BACK);
  localparam logic [11:0] VA_END  = 12'(V_SYNC + V_BACK + V_DISP);
  localparam logic [11:0] HS_W    = 12'(H_SYNC);
  localparam logic [11:0] VS_W    = 12'(V_SYNC);
  // Level driven on the sync outputs while the pulse is inactive.
  localparam logic        SYNC_IDLE = (SYNC_POL == 0);

  logic [11:0] h_cnt;
  logic [11:0] v_cnt;

  logic        req_c;
  logic        hs_s0, vs_s0, fs_s0;
  logic        hs_s1, vs_s1, fs_s1, de_s1;
  logic [23:0] rgb_exp;
  logic [23:0] rgb_src;

  always_ff @(posedge hdmi_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_TOTAL - 12'd1) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_TOTAL - 12'd1) ? 12'd0 : v_cnt + 12'd1;
    end else begin
      h_cnt <= h_cnt + 12'd1;
    end
  end

  assign req_c = (h_cnt >= HA) && (h_cnt < HA_END) &&
                 (v_cnt >= VA) && (v_cnt < VA_END);

  // Stage 0: request and raw timing terms.
  always_ff @(posedge hdmi_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      data_req   <= 1'b0;
      pixel_xpos <= '0;
      pixel_ypos <= '0;
      hs_s0      <= SYNC_IDLE;
      vs_s0      <= SYNC_IDLE;
      fs_s0      <= 1'b0;
    end else begin
      data_req   <= req_c;
      pixel_xpos <= req_c ? 11'(h_cnt - HA) : 11'd0;
      pixel_ypos <= req_c ? 11'(v_cnt - VA) : 11'd0;
      hs_s0      <= (h_cnt < HS_W) ^ SYNC_IDLE;
      vs_s0      <= (v_cnt < VS_W) ^ SYNC_IDLE;
      fs_s0      <= (h_cnt == 12'd0) && (v_cnt == 12'd0);
    end
  end

  // Stage 1 (overlay is fetching) and stage 2 (outputs).
  always_ff @(posedge hdmi_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      hs_s1       <= SYNC_IDLE;
      vs_s1       <= SYNC_IDLE;
      fs_s1       <= 1'b0;
      de_s1       <= 1'b0;
      video_hs    <= SYNC_IDLE;
      video_vs    <= SYNC_IDLE;
      video_de    <= 1'b0;
      frame_start <= 1'b0;
      video_rgb   <= '0;
    end else begin
      hs_s1       <= hs_s0;
      vs_s1       <= vs_s0;
      fs_s1       <= fs_s0;
      de_s1       <= data_req;
      video_hs    <= hs_s1;
      video_vs    <= vs_s1;
      video_de    <= de_s1;
      frame_start <= fs_s1;
      // pixel_data carries the reply to the stage-1 request; outside the
      // active window it is don't-care and must not leak onto the link.
      video_rgb   <= de_s1 ? rgb_src : 24'd0;
    end
  end

  // RGB565 -> RGB888 by replicating the top bits into the low bits.
  assign rgb_exp = {pixel_data[15:11], pixel_data[15:13],
                    pixel_data[10:5],  pixel_data[10:9],
                    pixel_data[4:0],   pixel_data[4:2]};

`ifdef HDMI_TIMING_GEN_TEST_PATTERN_EN
  localparam logic [10:0] BAR_W = 11'(H_DISP / 8);

  logic [10:0] xpos_s1;
  logic        pattern_q;
  logic [2:0]  bar_idx;
  logic [23:0] bar_rgb;

  always_ff @(posedge hdmi_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      xpos_s1   <= '0;
      pattern_q <= 1'b0;
    end else begin
      xpos_s1 <= pixel_xpos;
      // Latch once per frame so a bar pattern never switches mid-frame.
      if (frame_start) pattern_q <= pattern_en;
    end
  end

  always_comb begin
    bar_idx = 3'(xpos_s1 / BAR_W);
    bar_rgb = 24'h000000;
    case (bar_idx)
      3'd0: bar_rgb = 24'hFFFFFF;
      3'd1: bar_rgb = 24'hFFFF00;
      3'd2: bar_rgb = 24'h00FFFF;
      3'd3: bar_rgb = 24'h00FF00;
      3'd4: bar_rgb = 24'hFF00FF;
      3'd5: bar_rgb = 24'hFF0000;
      3'd6: bar_rgb = 24'h0000FF;
      default: bar_rgb = 24'h000000;
    endcase
  end

  assign rgb_src = pattern_q ? bar_rgb : rgb_exp;
`else
  logic unused_pattern_en;
  assign unused_pattern_en = pattern_en;
  assign rgb_src           = rgb_exp;
`endif

endmodule
